// File: rtl/store_addr_checker_pkg.sv
// store_addr_checker_pkg: shared sizes and constants for the store address checker
package store_addr_checker_pkg;
  localparam int SAC_DEPTH = 4;
  localparam int SAC_TAGW = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [SAC_TAGW-1:0] NULL_TAG = '0;
endpackage

// File: rtl/store_match_cam.sv
// store_match_cam: flags whether any valid entry address equals the check address
module store_match_cam #(
  parameter int N = 5,
  parameter int W = 32
) (
  input  logic [N-1:0][W-1:0] entry_addr,
  input  logic [N-1:0]        entry_valid,
  input  logic [W-1:0]        chk_addr,
  output logic                any_match
);
  always_comb begin
    any_match = 1'b0;
    for (int i = 0; i < N; i++) any_match = any_match | (entry_valid[i] && entry_addr[i] == chk_addr);
  end
endmodule

// File: rtl/store_addr_checker.sv
// store_addr_checker: in-order store buffer that tells a waiting load when no pending store aliases it
module store_addr_checker
  import store_addr_checker_pkg::*;
#(
  parameter int DEPTH = SAC_DEPTH,
  parameter int TAGW = SAC_TAGW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            st_valid,
  input  logic [TAGW-1:0] st_tag,
  input  logic [AW-1:0]   st_addr,
  input  logic [DW-1:0]   st_data,
  output logic            st_full,
  input  logic            chk_req,
  input  logic [AW-1:0]   chk_addr,
  input  logic [TAGW-1:0] chk_tag,
  output logic            address_neq_stores,
  input  logic            commit,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [TAGW-1:0] mem_tag
);
  localparam int PW = $clog2(DEPTH);
  logic [PW-1:0] head, tail;
  logic [PW:0] count;
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [TAGW-1:0] tag_q [DEPTH];
  logic chk_valid;
  logic [AW-1:0] chk_addr_q;
  logic [TAGW-1:0] chk_tag_q;
  logic push_ok, commit_ok, any_match;
  logic [DEPTH:0][AW-1:0] cam_addr;
  logic [DEPTH:0] cam_valid;
  assign st_full = count == (PW+1)'(DEPTH);
  assign push_ok = st_valid && !st_full;
  assign commit_ok = commit && count != '0;
  // the extra CAM slot covers a store arriving in the same cycle as the check
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cam_addr[i] = addr_q[i];
      cam_valid[i] = {1'b0, PW'(i) - head} < count;
    end
    cam_addr[DEPTH] = st_addr;
    cam_valid[DEPTH] = push_ok;
  end
  store_match_cam #(.N(DEPTH + 1), .W(AW)) u_cam (
    .entry_addr (cam_addr),
    .entry_valid(cam_valid),
    .chk_addr   (chk_req ? chk_addr : chk_addr_q),
    .any_match  (any_match)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      chk_valid <= 1'b0;
      chk_addr_q <= '0;
      chk_tag_q <= TAGW'(NULL_TAG);
      address_neq_stores <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_tag <= TAGW'(NULL_TAG);
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      chk_valid <= 1'b0;
      address_neq_stores <= 1'b0;
      mem_we <= 1'b0;
    end else begin
      if (push_ok) begin
        addr_q[tail] <= st_addr;
        data_q[tail] <= st_data;
        tag_q[tail] <= st_tag;
        tail <= tail + 1'b1;
      end
      mem_we <= commit_ok;
      if (commit_ok) begin
        mem_addr <= addr_q[head];
        mem_wdata <= data_q[head];
        mem_tag <= tag_q[head];
        head <= head + 1'b1;
      end
      count <= count + (PW+1)'(push_ok) - (PW+1)'(commit_ok);
      if (chk_req) begin
        chk_addr_q <= chk_addr;
        chk_tag_q <= chk_tag;
      end
      chk_valid <= chk_valid | chk_req;
      address_neq_stores <= (chk_valid | chk_req) & ~any_match;
    end
  end
endmodule

// File: tb/tb_store_addr_checker.sv
// tb_store_addr_checker: randomized scoreboard bench against a queue-based store buffer model
module tb_store_addr_checker;
  logic clk = 1'b0;
  logic reset, flush, st_valid, chk_req, commit;
  logic [31:0] st_addr, st_data, chk_addr;
  logic [5:0] st_tag, chk_tag;
  logic st_full, address_neq_stores, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [5:0] mem_tag;

  typedef struct {logic [31:0] a; logic [31:0] d; logic [5:0] t;} st_t;
  typedef struct {int cyc; logic ans; logic full; logic we; logic rst;} exp_t;

  st_t sq[$];
  st_t mem_q[$];
  exp_t exp_q[$];
  bit m_cv = 0;
  logic [31:0] m_lat = '0;
  int checks = 0, errors = 0, cyc = 0;

  store_addr_checker dut (
    .clk(clk), .reset(reset), .flush(flush),
    .st_valid(st_valid), .st_tag(st_tag), .st_addr(st_addr), .st_data(st_data), .st_full(st_full),
    .chk_req(chk_req), .chk_addr(chk_addr), .chk_tag(chk_tag), .address_neq_stores(address_neq_stores),
    .commit(commit), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_tag(mem_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, req, cyc);
    end
  endtask

  task automatic clr();
    reset = 0; flush = 0; st_valid = 0; chk_req = 0; commit = 0;
    st_addr = '0; st_data = '0; st_tag = '0; chk_addr = '0; chk_tag = '0;
  endtask

  task automatic tick();
    exp_t e;
    bit pok, cok, m;
    logic [31:0] ca;
    e.cyc = cyc + 1; e.rst = reset; e.ans = 0; e.we = 0;
    if (reset || flush) begin
      sq.delete();
      m_cv = 0;
      if (reset) m_lat = '0;
    end else begin
      pok = st_valid && sq.size() < 4;
      cok = commit && sq.size() > 0;
      ca = chk_req ? chk_addr : m_lat;
      m = pok && st_addr == ca;
      foreach (sq[i]) if (sq[i].a == ca) m = 1;
      m_cv = m_cv | chk_req;
      if (chk_req) m_lat = chk_addr;
      e.ans = m_cv && !m;
      e.we = cok;
      if (cok) mem_q.push_back(sq.pop_front());
      if (pok) sq.push_back('{st_addr, st_data, st_tag});
    end
    e.full = sq.size() == 4;
    exp_q.push_back(e);
    @(posedge clk); #1;
    clr();
  endtask

  task automatic push(input logic [31:0] a);
    st_valid = 1; st_addr = a; st_data = a ^ 32'h5a5a_0000; st_tag = 6'(a >> 4) | 6'd1;
  endtask

  task automatic check(input logic [31:0] a);
    chk_req = 1; chk_addr = a; chk_tag = 6'(a >> 3) | 6'd1;
  endtask

  initial begin
    exp_t e;
    st_t s;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("address_neq_stores", 32'(address_neq_stores), 32'(e.ans));
        chk("st_full", 32'(st_full), 32'(e.full));
        chk("mem_we", 32'(mem_we), 32'(e.we));
        if (e.rst) begin
          chk("reset_mem_addr", mem_addr, 32'h0);
          chk("reset_mem_wdata", mem_wdata, 32'h0);
          chk("reset_mem_tag", 32'(mem_tag), 32'h0);
        end
      end
      if (mem_we === 1'b1) begin
        if (mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mem_write: unexpected write to %h, none required", mem_addr);
        end else begin
          s = mem_q.pop_front();
          chk("mem_addr", mem_addr, s.a);
          chk("mem_wdata", mem_wdata, s.d);
          chk("mem_tag", 32'(mem_tag), 32'(s.t));
        end
      end
    end
  end

  initial begin
    clr();
    reset = 1; tick();
    reset = 1; tick();
    tick();
    // no alias: two stores, load elsewhere
    push(32'h100); tick();
    push(32'h200); tick();
    check(32'h300); tick();
    tick();
    commit = 1; tick();
    commit = 1; tick();
    tick();
    flush = 1; tick();
    // alias drains after commit
    push(32'h100); tick();
    check(32'h100); tick();
    tick();
    commit = 1; tick();
    tick(); tick();
    flush = 1; tick();
    // fill, overflow push ignored, drain in order
    for (int i = 1; i <= 4; i++) begin push(32'(i) << 8); tick(); end
    push(32'h500); commit = 0; tick();
    push(32'h500); commit = 1; tick();
    for (int i = 0; i < 4; i++) begin commit = 1; tick(); end
    commit = 1; tick();
    tick();
    // same-cycle push and check
    check(32'h40); push(32'h40); tick();
    tick();
    commit = 1; tick();
    tick(); tick();
    // flush beats commit
    flush = 1; tick();
    for (int i = 1; i <= 3; i++) begin push(32'(i) << 4); tick(); end
    check(32'h10); tick();
    flush = 1; commit = 1; tick();
    tick();
    // reset beats a pending commit
    push(32'h700); tick();
    push(32'h800); tick();
    check(32'h900); commit = 1; tick();
    push(32'ha00); commit = 1; reset = 1; tick();
    tick(); tick();
    for (int n = 0; n < 600; n++) begin
      reset = $urandom_range(0, 99) == 0;
      flush = $urandom_range(0, 39) == 0;
      st_valid = $urandom_range(0, 1) == 1;
      st_addr = 32'($urandom_range(0, 7)) << 4;
      st_data = $urandom;
      st_tag = 6'($urandom_range(1, 63));
      chk_req = $urandom_range(0, 5) == 0;
      chk_addr = 32'($urandom_range(0, 7)) << 4;
      chk_tag = 6'($urandom_range(1, 63));
      commit = $urandom_range(0, 2) == 0;
      tick();
    end
    tick(); tick();
    #5;
    chk("mem_q_drained", 32'(mem_q.size()), 32'h0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_addr_checker.md
STORE_ADDR_CHECKER -- requirements
Module: store_addr_checker

Interface
REQ-001 Parameter DEPTH, default 4, number of pending-store entries (power of two).
REQ-002 Parameter TAGW, default 6, tag width; tag 0 means "no tag".
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 flush  in  1  synchronous pipeline flush.
REQ-006 st_valid  in  1  push request for a resolved store (address and data known).
REQ-007 st_tag  in  TAGW  tag of the pushed store.
REQ-008 st_addr  in  32  effective address of the pushed store.
REQ-009 st_data  in  32  data of the pushed store.
REQ-010 st_full  out  1  buffer holds DEPTH entries (combinational from count).
REQ-011 chk_req  in  1  one-cycle address-check pulse from the load reservation station.
REQ-012 chk_addr  in  32  load effective address accompanying chk_req.
REQ-013 chk_tag  in  TAGW  load tag accompanying chk_req.
REQ-014 address_neq_stores  out  1  registered; 1 means no pending store matches the latched load address.
REQ-015 commit  in  1  retire the oldest store to memory.
REQ-016 mem_we  out  1  registered one-cycle memory write strobe.
REQ-017 mem_addr  out  32  registered write address.
REQ-018 mem_wdata  out  32  registered write data.
REQ-019 mem_tag  out  TAGW  registered tag of the retired store.

Function
REQ-020 Entries SHALL form an in-order circular FIFO: head pointer, tail pointer and count in 0..DEPTH; pointers wrap modulo DEPTH.
REQ-021 A push SHALL be accepted when st_valid=1 and count<DEPTH; a push while full SHALL be ignored, even if commit=1 in the same cycle.
REQ-022 A commit SHALL be accepted when commit=1 and count>0; the next cycle has mem_we=1 and mem_addr/mem_wdata/mem_tag equal to the head entry; a commit while empty SHALL be ignored and mem_we=0.
REQ-023 mem_we SHALL be 1 for exactly one cycle per accepted commit.
REQ-024 A simultaneous accepted push and commit SHALL leave count unchanged and move both pointers.
REQ-025 On chk_req=1 the block SHALL latch chk_addr and chk_tag and set a check-valid flag; a later chk_req SHALL overwrite the latched address and tag.
REQ-026 Each cycle the match SHALL be a 32-bit equality compare of the check address against every valid entry plus any push accepted in that cycle.
REQ-027 The check address SHALL be chk_addr when chk_req=1, otherwise the latched address.
REQ-028 An entry being committed in the same cycle SHALL still count as a match (conservative).
REQ-029 address_neq_stores SHALL be registered as (check-valid AND no match), so it is valid in the cycle after the chk_req pulse.
REQ-030 address_neq_stores SHALL then re-evaluate every cycle, so it rises once the matching stores drain.
REQ-031 While check-valid=0, address_neq_stores SHALL be 0.
REQ-032 flush SHALL clear count, both pointers and check-valid, and drive mem_we=0 and address_neq_stores=0 in the next cycle.
REQ-033 flush SHALL take priority over push, commit and chk_req in the same cycle.

Reset
REQ-034 With reset=1 at a clock edge: count, head and tail = 0; check-valid = 0; latched address and tag = 0; address_neq_stores = 0; mem_we = 0; mem_addr, mem_wdata and mem_tag = 0; st_full = 0.
REQ-035 reset SHALL take priority over flush, push, commit and chk_req.
REQ-036 Reset during a pending commit SHALL suppress that commit's mem_we.

Structure
REQ-037 The shared package SHALL hold DEPTH, TAGW, the 32-bit address/data widths and the null-tag constant 0.
REQ-038 The per-entry address comparator array SHALL be one sub-module, store_match_cam, with inputs: entry addresses, entry valid bits and check address; output: any_match.

Verification
REQ-039 Push stores to 0x100, then 0x200; chk_req with 0x300 -> address_neq_stores=1 in the next cycle.
REQ-040 Push a store to 0x100; chk_req with 0x100 -> address_neq_stores=0; commit -> mem_we=1, mem_addr=0x100; address_neq_stores rises to 1 the following cycle.
REQ-041 Push 4 stores -> st_full=1; a 5th push to 0x500 is ignored; 4 commits -> mem_addr follows push order and the count wraps to 0.
REQ-042 Same cycle: chk_req with 0x40 and push a store to 0x40 -> address_neq_stores=0.
REQ-043 With 3 entries, assert flush together with commit -> mem_we=0, count=0, address_neq_stores=0.
REQ-044 Assert reset mid-stream after 2 pushes and a commit -> all outputs return to their reset values next cycle, with no mem_we pulse.
